// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, write FSM states and tensorcore request type
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_t;

  typedef struct packed {
    logic [63:0] base;
    logic [7:0]  burst_num;
    logic [2:0]  burst_size;
  } wr_req_t;

  // True when the last byte of the burst lands in a different 4 KB page than the first.
  function automatic logic crosses_4k(wr_req_t r);
    logic [63:0] last;
    last = r.base + ((64'(r.burst_num) + 64'd1) << r.burst_size) - 64'd1;
    return r.base[63:12] != last[63:12];
  endfunction

endpackage

// File: rtl/axi_tensor_wr_if.sv
// rtl/axi_tensor_wr_if.sv - AXI4 write-channel (AW/W/B) bundle with master/slave views
interface axi_tensor_wr_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_tensor_wr.sv
// rtl/axi_tensor_wr.sv - single-outstanding AXI4 write master for tensorcore result bursts
module axi_tensor_wr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   wr_base,
  input  logic [LEN_WIDTH-1:0]    wr_burst_num,
  input  logic [2:0]              wr_burst_size,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [31:0]             wr_beat_id,
  output logic                    wr_done,
  output logic                    wr_err,
  input  logic                    wr_err_clr,
  axi_tensor_wr_if.master         m_axi
);

  wr_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [LEN_WIDTH:0]      cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    last_beat, aw_fire, w_fire, b_fire;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    last_beat = (cnt_q == {1'b0, len_q});
    aw_fire   = (state_q == ADDR) && m_axi.awready;
    w_fire    = (state_q == DATA) && wr_valid && m_axi.wready;
    b_fire    = (state_q == RESP) && m_axi.bvalid;
    case (state_q)
      IDLE: if (wr_req_valid) begin
        addr_d  = wr_base;
        len_d   = wr_burst_num;
        size_d  = wr_burst_size;
        cnt_d   = '0;
        state_d = ADDR;
      end
      ADDR: if (aw_fire) state_d = DATA;
      DATA: if (w_fire) begin
        cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = RESP;
      end
      RESP: if (b_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = b_fire;
    // A failing response in the same cycle as a clear keeps the error visible.
    if (b_fire && (m_axi.bresp != RESP_OKAY)) err_d = 1'b1;
    else if (wr_err_clr)                      err_d = 1'b0;
    else                                      err_d = err_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_req_ready  = (state_q == IDLE);
  assign m_axi.awvalid = (state_q == ADDR);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(len_q);
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = BURST_INCR;
  // W is a straight pass-through, gated so nothing leaks out before AW is accepted.
  assign m_axi.wvalid  = (state_q == DATA) && wr_valid;
  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = wr_strb;
  assign m_axi.wlast   = (state_q == DATA) && last_beat;
  assign wr_ready      = (state_q == DATA) && m_axi.wready;
  assign m_axi.bready  = (state_q == RESP);
  assign wr_beat_id    = 32'(cnt_q);
  assign wr_done       = done_q;
  assign wr_err        = err_q;

  wr_req_t aw_req;
  assign aw_req = '{base: 64'(addr_q), burst_num: 8'(len_q), burst_size: size_q};

  a_no_4k_cross: assert property (@(posedge aclk) disable iff (areset)
    m_axi.awvalid |-> !crosses_4k(aw_req));
  a_size_fits: assert property (@(posedge aclk) disable iff (areset)
    m_axi.awvalid |-> (size_q <= 3'($clog2(DATA_WIDTH/8))));
  a_no_stray_b: assert property (@(posedge aclk) disable iff (areset)
    m_axi.bvalid |-> (state_q == RESP));

endmodule

// File: tb/tb_axi_tensor_wr.sv
// tb/tb_axi_tensor_wr.sv - directed vector table plus randomized bursts for axi_tensor_wr
module tb_axi_tensor_wr;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int LW = 6;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] wr_base;
  logic [LW-1:0] wr_burst_num;
  logic [2:0]    wr_burst_size;
  logic          wr_req_valid, wr_req_ready;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_valid, wr_ready;
  logic [31:0]   wr_beat_id;
  logic          wr_done, wr_err, wr_err_clr;

  axi_tensor_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_tensor_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk(aclk), .areset(areset),
    .wr_base(wr_base), .wr_burst_num(wr_burst_num), .wr_burst_size(wr_burst_size),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_beat_id(wr_beat_id), .wr_done(wr_done), .wr_err(wr_err), .wr_err_clr(wr_err_clr),
    .m_axi(axi)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit err_model = 1'b0;

  typedef struct {
    logic [31:0] base;
    int          num;
    int          size;
    int          aw_stall;
    int          wmode;
    logic [1:0]  bresp;
    bit          clr_at_b;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge with wr_done expected high
  // (or right after a reset release when reset_at >= 0).
  task automatic run_burst(input logic [31:0] base, input int num, input int size,
                           input int aw_stall, input int wmode, input logic [1:0] bresp,
                           input bit clr_at_b, input int reset_at);
    int beat, hs, cyc, bdly;
    bit pend, vld, rdy, aw_ok;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    chk("req_ready_idle", wr_req_ready, 1);
    wr_base = base; wr_burst_num = num[LW-1:0]; wr_burst_size = size[2:0];
    wr_req_valid = 1'b1;
    #1 chk("awvalid_before_accept", axi.awvalid, 0);
    @(negedge aclk);
    wr_req_valid = 1'b0;
    wr_base = $urandom; wr_burst_num = LW'($urandom); wr_burst_size = 3'($urandom);
    #1 chk("done_single_pulse", wr_done, 0);
    aw_ok = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      axi.awready = (cyc >= aw_stall);
      wr_valid = 1'b1; wr_data = {8{$urandom}};
      #1;
      chk("awvalid", axi.awvalid, 1);
      chk("awaddr", axi.awaddr, base);
      chk("awlen", axi.awlen, num);
      chk("awsize", axi.awsize, size);
      chk("awburst", axi.awburst, 2'b01);
      chk("wr_ready_in_addr", wr_ready, 0);
      chk("wvalid_in_addr", axi.wvalid, 0);
      if (axi.awvalid && axi.awready) begin aw_ok = 1'b1; break; end
      @(negedge aclk);
    end
    chk("aw_handshake_seen", aw_ok, 1);
    @(negedge aclk);
    axi.awready = 1'b0;
    beat = 0; hs = 0; pend = 1'b0; vld = 1'b0; d = '0; s = '0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (reset_at >= 0 && beat == reset_at) begin
        wr_valid = 1'b1; axi.wready = 1'b1;
        #1 areset = 1'b1;
        #1;
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_beat_id", wr_beat_id, 0);
        chk("rst_wlast", axi.wlast, 0);
        err_model = 1'b0;
        chk("rst_err", wr_err, 0);
        wr_valid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        #1 chk("req_ready_after_rst", wr_req_ready, 1);
        return;
      end
      case (wmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (!pend) begin
        vld = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        d = {8{$urandom}}; s = SW'($urandom);
      end
      axi.wready = rdy; wr_valid = vld; wr_data = d; wr_strb = s;
      #1;
      chk("beat_id", wr_beat_id, beat);
      chk("wr_ready", wr_ready, rdy);
      chk("wvalid", axi.wvalid, vld);
      chk("wlast", axi.wlast, (beat == num));
      chk("wdata", axi.wdata, d);
      chk("wstrb", axi.wstrb, s);
      pend = vld && !rdy;
      if (vld && rdy) begin
        beat++; hs++;
        if (beat == num + 1) break;
      end
      @(negedge aclk);
    end
    chk("w_handshakes", hs, num + 1);
    @(negedge aclk);
    wr_valid = 1'b1; axi.wready = 1'b1;
    #1;
    chk("wvalid_in_resp", axi.wvalid, 0);
    chk("wr_ready_in_resp", wr_ready, 0);
    wr_valid = 1'b0;
    bdly = $urandom_range(0, 2);
    repeat (bdly) begin
      chk("bready_wait", axi.bready, 1);
      chk("done_early", wr_done, 0);
      @(negedge aclk);
    end
    axi.bvalid = 1'b1; axi.bresp = bresp; wr_err_clr = clr_at_b;
    #1 chk("bready", axi.bready, 1);
    if (bresp != 2'b00) err_model = 1'b1;
    else if (clr_at_b)  err_model = 1'b0;
    @(negedge aclk);
    axi.bvalid = 1'b0; wr_err_clr = 1'b0;
    #1;
    chk("done_pulse", wr_done, 1);
    chk("err_model", wr_err, err_model);
    chk("req_ready_on_done", wr_req_ready, 1);
  endtask

  initial begin
    int num, size, bytes;
    logic [31:0] base;
    areset = 1'b1;
    wr_base = '0; wr_burst_num = '0; wr_burst_size = '0; wr_req_valid = 1'b0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b1; wr_err_clr = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    repeat (2) @(negedge aclk);
    #1;
    chk("reset_awvalid", axi.awvalid, 0);
    chk("reset_wvalid", axi.wvalid, 0);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_bready", axi.bready, 0);
    chk("reset_done", wr_done, 0);
    chk("reset_err", wr_err, 0);
    chk("reset_beat_id", wr_beat_id, 0);
    chk("reset_awaddr", axi.awaddr, 0);
    chk("reset_awlen", axi.awlen, 0);
    chk("reset_req_ready", wr_req_ready, 1);
    wr_valid = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    vecs.push_back('{32'h0000_1000, 3, 5, 0, 0, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_2000, 0, 5, 0, 0, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_3040, 2, 2, 5, 0, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_4000, 7, 5, 0, 1, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_5000, 1, 3, 1, 0, 2'b10, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_5800, 0, 4, 0, 0, 2'b00, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_6000, 2, 5, 0, 0, 2'b11, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_7000, 0, 0, 0, 0, 2'b00, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      run_burst(vecs[i].base, vecs[i].num, vecs[i].size, vecs[i].aw_stall,
                vecs[i].wmode, vecs[i].bresp, vecs[i].clr_at_b, -1);
      chk($sformatf("vec%0d_err", i), wr_err, vecs[i].exp_err);
    end

    @(negedge aclk);
    run_burst(32'h0000_8000, 7, 5, 0, 0, 2'b00, 1'b0, 2);
    run_burst(32'h0000_9000, 7, 5, 0, 0, 2'b00, 1'b0, -1);
    chk("post_reset_err", wr_err, 0);

    for (int k = 0; k < 15; k++) begin
      num   = $urandom_range(0, 63);
      size  = $urandom_range(0, 5);
      bytes = (num + 1) << size;
      base  = ($urandom & 32'hFFFF_F000) + 32'($urandom_range(0, (4096 - bytes) / 4) * 4);
      run_burst(base, num, size, $urandom_range(0, 3), $urandom_range(0, 2),
                2'($urandom), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) @(negedge aclk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
